// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the FIFO read ports, the arbiter and the
// downstream consumer. The arbiter uses the master modport.
interface fifo_rd_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DSIZE   = 8
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC-1:0]       rempty;
  logic [NUM_SRC*DSIZE-1:0] rdata;
  logic [NUM_SRC-1:0]       rinc;
  logic                     out_valid;
  logic [DSIZE-1:0]         out_data;
  logic [SW-1:0]            out_src;
  logic                     out_ready;
  logic                     busy;

  modport master (
    input  src_en, rempty, rdata, out_ready,
    output rinc, out_valid, out_data, out_src, busy
  );

  modport slave (
    output src_en, rempty, rdata, out_ready,
    input  rinc, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler: drains NUM_SRC FIFO read ports in bursts of at
// most BURST_LEN words onto one registered valid/ready output stream.
module fifo_rd_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rd_arbiter_if.master bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam logic [3:0] BLEN = 4'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      last_grant, last_nx;
  logic [SW-1:0]      grant, grant_nx;
  logic [3:0]         count, count_nx;
  logic [SW-1:0]      winner;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] rinc_c;
  logic               slot;
  logic               pop;
  logic [DSIZE-1:0]   src_data [NUM_SRC];
  logic [DSIZE-1:0]   sel_data;

  logic               vld_p1;
  logic [DSIZE-1:0]   data_p1;
  logic [SW-1:0]      src_p1;

  // First requester found scanning upward from last+1, wrapping at NUM_SRC.
  function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                            input logic [SW-1:0] last);
    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    pick = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SW'((int'(last) + k) % NUM_SRC);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Unpack the flattened read data into one word per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_data[i] = bus.rdata[i*DSIZE +: DSIZE];
  end

  // Request, pop decision and the single-hot pop strobe.
  always_comb begin
    req      = bus.src_en & ~bus.rempty;
    slot     = ~vld_p1 | bus.out_ready;
    winner   = rr_pick(req, last_grant);
    sel_data = src_data[grant];
    pop      = (state == BURST) && req[grant] && slot && (count < BLEN) && !rrst;
    rinc_c   = '0;
    if (pop) rinc_c[grant] = 1'b1;
  end

  // Next-state logic: IDLE arbitrates for one cycle, BURST pops until the
  // burst limit is hit or the granted source stops requesting.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last_grant;
    count_nx = count;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = winner;
          last_nx  = winner;
          count_nx = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          count_nx = count + 4'd1;
          if (count + 4'd1 == BLEN) state_nx = IDLE;
        end else if (!req[grant]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM and arbitration registers; reset restarts priority at source 0.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= IDLE;
      last_grant <= SW'(NUM_SRC - 1);
      grant      <= '0;
      count      <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_nx;
      grant      <= grant_nx;
      count      <= count_nx;
    end
  end

  // ---- stage p1: output register, loaded on pop, cleared on accept ----
  always_ff @(posedge rclk) begin
    if (rrst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      src_p1  <= grant;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.rinc      = rinc_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.busy      = (state == BURST);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: bench-side FIFO queues, a rule-level reference
// model of the scheduler and per-source delivery scoreboards.
module tb_fifo_rd_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic clk;
  logic rst;

  fifo_rd_arbiter_if #(.NUM_SRC(NS), .DSIZE(DW)) bus ();

  fifo_rd_arbiter #(.NUM_SRC(NS), .DSIZE(DW), .BURST_LEN(BL)) dut (
    .rclk (clk),
    .rrst (rst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fq [NS][$];   // FIFO contents as seen by the DUT
  logic [DW-1:0] gq [NS][$];   // words still owed to the consumer, per source
  int            dlv_src [$];  // source order of accepted words
  int            popcnt [NS];

  // reference model state
  bit            m_busy = 1'b0;
  int            m_g    = 0;
  int            m_last = NS - 1;
  int            m_cnt  = 0;
  bit            m_ov   = 1'b0;
  logic [DW-1:0] m_od   = '0;
  int            m_os   = 0;
  bit            m_req [NS];
  bit            m_pop;
  logic [NS-1:0] m_rinc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] v);
    fq[s].push_back(v);
    gq[s].push_back(v);
  endtask

  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      bus.rempty[i] = (fq[i].size() == 0);
      bus.rdata[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock cycle: check outputs against the model, then advance both.
  task automatic step();
    logic [NS-1:0] rinc_cap;
    bit            acc;
    int            w;
    bit            found;
    refresh();
    #1;
    for (int i = 0; i < NS; i++) m_req[i] = bus.src_en[i] && (fq[i].size() != 0);
    m_pop  = !rst && m_busy && m_req[m_g] && (!m_ov || bus.out_ready) && (m_cnt < BL);
    m_rinc = '0;
    if (m_pop) m_rinc[m_g] = 1'b1;
    chk("rinc", bus.rinc, m_rinc);
    chk("busy", bus.busy, m_busy);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data", bus.out_data, m_od);
    chk("out_src", bus.out_src, m_os);
    chk("rinc_onehot", $onehot0(bus.rinc), 1);
    chk("rinc_on_empty", |(bus.rinc & bus.rempty), 0);
    acc = !rst && m_ov && bus.out_ready;
    if (acc) begin
      dlv_src.push_back(m_os);
      if (gq[m_os].size() != 0) chk("deliver_word", bus.out_data, gq[m_os].pop_front());
      else chk("deliver_extra", gq[m_os].size(), 1);
    end
    rinc_cap = bus.rinc;
    @(posedge clk);
    if (rst) begin
      if (m_ov && !acc) void'(gq[m_os].pop_front());
      m_busy = 0; m_last = NS - 1; m_g = 0; m_cnt = 0;
      m_ov = 0; m_od = '0; m_os = 0;
    end else begin
      if (m_pop) begin
        m_od = fq[m_g][0]; m_os = m_g; m_ov = 1;
      end else if (acc) begin
        m_ov = 0;
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= NS; k++) begin
          w = (m_last + k) % NS;
          if (!found && m_req[w]) begin
            found = 1; m_g = w; m_last = w; m_cnt = 0; m_busy = 1;
          end
        end
      end else if (m_pop) begin
        m_cnt++;
        if (m_cnt == BL) m_busy = 0;
      end else if (!m_req[m_g]) begin
        m_busy = 0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (rinc_cap[i] && fq[i].size() != 0) begin
        void'(fq[i].pop_front());
        popcnt[i]++;
      end
    end
    @(negedge clk);
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NS; i++) popcnt[i] = 0;
    dlv_src.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [DW-1:0] held;
    int            n0;
    int            guard;
    rst = 1'b1;
    bus.src_en = '0;
    bus.out_ready = 1'b0;
    refresh();
    @(posedge clk);
    @(negedge clk);

    // Reset and a six-word FIFO0: a 4-word burst, re-grant, then 2 more.
    bus.src_en = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(0, 8'h11 + 8'(i));
    do_reset();
    #1 chk("t1_idle_rinc", bus.rinc, 0);
    run(12);
    chk("t1_words_src0", dlv_src.size(), 6);
    chk("t1_fifo0_empty", fq[0].size(), 0);

    // Round-robin over four two-word FIFOs.
    for (int s = 0; s < NS; s++) begin
      push(s, 8'(8'h20 + s * 16));
      push(s, 8'(8'h21 + s * 16));
    end
    do_reset();
    run(16);
    chk("t2_count", dlv_src.size(), 8);
    for (int i = 0; i < 8 && i < dlv_src.size(); i++) chk("t2_order", dlv_src[i], i / 2);

    // Backpressure: stall for 5 cycles after the first word of a burst.
    for (int i = 0; i < 4; i++) push(0, 8'h40 + 8'(i));
    do_reset();
    guard = 0;
    while (!m_ov && guard < 10) begin step(); guard++; end
    chk("t3_first_word_seen", m_ov, 1);
    bus.out_ready = 1'b0;
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_data", bus.out_data, held);
      chk("t3_stall_pops", popcnt[0], 1);
    end
    bus.out_ready = 1'b1;
    run(8);
    chk("t3_all_delivered", gq[0].size(), 0);

    // Wrap/priority with source 2 masked off.
    bus.src_en = 4'b1011;
    push(1, 8'h51); push(1, 8'h52);
    push(2, 8'h61); push(2, 8'h62);
    do_reset();
    run(10);
    chk("t4_first_src", (dlv_src.size() != 0) ? dlv_src[0] : -1, 1);
    chk("t4_src2_pops", popcnt[2], 0);
    chk("t4_src2_left", fq[2].size(), 2);
    bus.src_en = 4'b1111;
    run(8);

    // Mid-burst disable of source 0 after two pops.
    push(0, 8'h71); push(0, 8'h72); push(0, 8'h73); push(0, 8'h74);
    push(1, 8'h81); push(1, 8'h82);
    do_reset();
    guard = 0;
    while (popcnt[0] < 2 && guard < 10) begin step(); guard++; end
    bus.src_en = 4'b1110;
    run(10);
    n0 = 0;
    foreach (dlv_src[i]) if (dlv_src[i] == 0) n0++;
    chk("t5_src0_words", n0, 2);
    chk("t5_next_src", (dlv_src.size() > 2) ? dlv_src[2] : -1, 1);
    chk("t5_fifo0_left", fq[0].size(), 2);
    bus.src_en = 4'b1111;
    run(10);

    // Reset while a word is held in the output register.
    for (int i = 0; i < 4; i++) push(2, 8'h90 + 8'(i));
    do_reset();
    bus.out_ready = 1'b0;
    guard = 0;
    while (!m_ov && guard < 10) begin step(); guard++; end
    push(1, 8'hA1); push(1, 8'hA2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_valid_cleared", bus.out_valid, 0);
    chk("t6_busy_cleared", bus.busy, 0);
    chk("t6_rinc_idle", bus.rinc, 0);
    step();
    #1 chk("t6_lowest_grant", bus.rinc, 4'b0010);
    bus.out_ready = 1'b1;
    run(20);

    // Randomized traffic with enable toggling, stalls and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) bus.src_en[$urandom_range(NS-1)] ^= 1'b1;
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        n0 = $urandom_range(NS-1);
        if (fq[n0].size() < 12) push(n0, 8'($urandom));
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    bus.src_en = 4'b1111;
    bus.out_ready = 1'b1;
    run(80);
    for (int s = 0; s < NS; s++) begin
      chk("drain_fifo", fq[s].size(), 0);
      chk("drain_owed", gq[s].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
